// File: rtl/uart_tx_sched_pkg.sv
// Shared MiniUART register map and scheduler state encodings.
package uart_tx_sched_pkg;

  // UART word addresses as seen on ADD_O (byte address bits [4:2]).
  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR  = 3'd1;
  localparam logic [2:0] OFF_UART_DIVR = 3'd2;
  localparam logic [2:0] OFF_UART_DIVT = 3'd3;

  localparam int LSR_TS_BIT = 5;

  typedef logic [2:0] state_t;

  localparam state_t CFG_R = 3'd0;
  localparam state_t CFG_T = 3'd1;
  localparam state_t IDLE  = 3'd2;
  localparam state_t POLL  = 3'd3;
  localparam state_t SEND  = 3'd4;
  localparam state_t WAIT  = 3'd5;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping; purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// MiniUART bus master: programs divisors, then round-robin forwards requester bytes
// to the transmitter, polling LSR for idle and holding off SETTLE cycles after each write.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [15:0] DIVR_INIT = 16'd0,
  parameter logic [15:0] DIVT_INIT = 16'd0,
  parameter int          SETTLE    = 3
) (
  input  logic                 CLK_I,
  input  logic                 RST_N_I,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 cfg_done,
  output logic                 busy,
  output logic [2:0]           ADD_O,
  output logic [31:0]          DAT_O,
  input  logic [31:0]          DAT_I,
  output logic                 STB_O,
  output logic                 WE_O
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t        state;
  state_t        nxt;
  logic [IW-1:0] rr_ptr;
  logic [3:0]    settle_cnt;
  logic [7:0]    byte_buf;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             tx_idle;
  logic             unused_dat;

  logic        stb_d;
  logic        we_d;
  logic [2:0]  add_d;
  logic [31:0] dat_d;

  assign tx_idle    = DAT_I[LSR_TS_BIT];
  assign unused_dat = ^{DAT_I[31:LSR_TS_BIT+1], DAT_I[LSR_TS_BIT-1:0]};

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= CFG_R;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      CFG_R:   nxt = CFG_T;
      CFG_T:   nxt = IDLE;
      IDLE:    if (gnt_any) nxt = POLL;
      POLL:    if (tx_idle) nxt = SEND;
      SEND:    nxt = WAIT;
      WAIT:    if (settle_cnt <= 4'd1) nxt = IDLE;
      default: nxt = CFG_R;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      rr_ptr     <= '0;
      settle_cnt <= '0;
      byte_buf   <= '0;
      cfg_done   <= 1'b0;
    end else begin
      if (state == CFG_T) begin
        cfg_done <= 1'b1;
      end
      if (state == IDLE && gnt_any) begin
        byte_buf <= req_data[{gnt_idx, 3'b000} +: 8];
        rr_ptr   <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
      if (state == SEND) begin
        settle_cnt <= 4'(SETTLE);
      end else if (state == WAIT) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    stb_d     = 1'b0;
    we_d      = 1'b0;
    add_d     = '0;
    dat_d     = '0;
    req_ready = '0;
    case (state)
      CFG_R: begin
        stb_d = 1'b1;
        we_d  = 1'b1;
        add_d = OFF_UART_DIVR;
        dat_d = {16'b0, DIVR_INIT};
      end
      CFG_T: begin
        stb_d = 1'b1;
        we_d  = 1'b1;
        add_d = OFF_UART_DIVT;
        dat_d = {16'b0, DIVT_INIT};
      end
      IDLE: req_ready = gnt;
      POLL: begin
        stb_d = 1'b1;
        add_d = OFF_UART_LSR;
      end
      SEND: begin
        stb_d = 1'b1;
        we_d  = 1'b1;
        add_d = OFF_UART_DATA;
        dat_d = {24'b0, byte_buf};
      end
      default: begin
        stb_d = 1'b0;
      end
    endcase
  end

  // CFG_R is the reset state, so the bus is forced quiet while reset is held.
  assign STB_O = RST_N_I & stb_d;
  assign WE_O  = RST_N_I & we_d;
  assign ADD_O = RST_N_I ? add_d : 3'd0;
  assign DAT_O = RST_N_I ? dat_d : 32'd0;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level model checked every cycle plus directed scenarios.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  localparam int N   = 4;
  localparam int ST  = 3;
  localparam int LIM = 1000;

  logic        CLK_I = 1'b0;
  logic        RST_N_I;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_done;
  logic        busy;
  logic [2:0]  ADD_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        STB_O;
  logic        WE_O;
  logic        lsr_ts;

  int tests = 0;
  int fails = 0;
  int since_rel = 0;

  int         phase = 0;    // 0: idle or settling, 1: polling, 2: data write due
  int         mptr = 0;
  int         idle_due = 2;
  logic [7:0] exp_byte = 8'h00;
  logic [7:0] wr_log[$];

  uart_tx_sched #(
    .N_REQ     (N),
    .DIVR_INIT (16'h0145),
    .DIVT_INIT (16'h0A2C),
    .SETTLE    (ST)
  ) dut (
    .CLK_I     (CLK_I),
    .RST_N_I   (RST_N_I),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_done  (cfg_done),
    .busy      (busy),
    .ADD_O     (ADD_O),
    .DAT_O     (DAT_O),
    .DAT_I     (DAT_I),
    .STB_O     (STB_O),
    .WE_O      (WE_O)
  );

  assign DAT_I = (ADD_O == OFF_UART_LSR) ? (32'(lsr_ts) << LSR_TS_BIT) : 32'h0;

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK_I) since_rel <= !RST_N_I ? 0 : since_rel + 1;

  // Per-cycle model: bus activity follows from grant/poll/write transactions.
  always @(negedge CLK_I) begin : cmp
    logic [3:0]  er;
    logic        il;
    int          pick;
    logic        es, ew;
    logic [2:0]  ea;
    logic [31:0] ed;
    if (!RST_N_I) begin
      chk("rst_stb", STB_O, 0);
      chk("rst_we", WE_O, 0);
      chk("rst_add", ADD_O, 0);
      chk("rst_dat", DAT_O, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_cfg_done", cfg_done, 0);
      chk("rst_busy", busy, 1);
      phase = 0; mptr = 0; idle_due = 2;
    end else begin
      il   = (phase == 0) && (since_rel >= idle_due);
      er   = 4'b0000;
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(mptr + k) % N]) pick = (mptr + k) % N;
      if (il && pick >= 0) er = 4'(1) << pick;
      chk("cfg_done", cfg_done, since_rel >= 2);
      chk("busy", busy, !il);
      chk("req_ready", req_ready, er);
      es = 0; ew = 0; ea = 3'd0; ed = 32'h0;
      if (since_rel == 0) begin
        es = 1; ew = 1; ea = OFF_UART_DIVR; ed = 32'h0000_0145;
      end else if (since_rel == 1) begin
        es = 1; ew = 1; ea = OFF_UART_DIVT; ed = 32'h0000_0A2C;
      end else if (phase == 1) begin
        es = 1; ea = OFF_UART_LSR;
      end else if (phase == 2) begin
        es = 1; ew = 1; ea = OFF_UART_DATA; ed = {24'h0, exp_byte};
      end
      chk("stb", STB_O, es);
      chk("we", WE_O, ew);
      if (es) chk("add", ADD_O, ea);
      if (ew) chk("dat", DAT_O, ed);
      if (STB_O && WE_O && ADD_O == OFF_UART_DATA) wr_log.push_back(DAT_O[7:0]);
      if (phase == 2) begin
        phase = 0;
        idle_due = since_rel + ST + 1;
      end else if (phase == 1 && lsr_ts) begin
        phase = 2;
      end
      if (er != 0) begin
        phase = 1;
        exp_byte = req_data[8*pick +: 8];
        mptr = (pick + 1) % N;
      end
    end
  end

  task automatic wait_grant(input string nm);
    int n;
    for (n = 0; n < LIM; n++) begin
      @(negedge CLK_I);
      if (req_ready != 0) break;
    end
    chk({nm, "_timeout"}, n >= LIM, 0);
  endtask

  task automatic wait_write(input string nm);
    int n;
    for (n = 0; n < LIM; n++) begin
      @(negedge CLK_I);
      if (STB_O && WE_O && ADD_O == OFF_UART_DATA) break;
    end
    chk({nm, "_timeout"}, n >= LIM, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    for (n = 0; n < LIM; n++) begin
      @(negedge CLK_I);
      if (!busy) break;
    end
    chk({nm, "_timeout"}, n >= LIM, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    RST_N_I   = 1'b0;
    req_valid = 4'hF;
    lsr_ts    = 1'b1;
    for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'(8'hA0 + k);

    @(negedge CLK_I);
    chk("lit_rst_stb", STB_O, 0);
    chk("lit_rst_busy", busy, 1);
    repeat (3) @(posedge CLK_I);
    #1 RST_N_I = 1'b1;

    // Configuration writes, then continuous round-robin from all requesters.
    @(negedge CLK_I);
    chk("lit_divr_add", ADD_O, OFF_UART_DIVR);
    chk("lit_divr_dat", DAT_O, 32'h145);
    chk("lit_divr_ready", req_ready, 0);
    @(negedge CLK_I);
    chk("lit_divt_dat", DAT_O, 32'hA2C);
    chk("lit_divt_ready", req_ready, 0);
    @(negedge CLK_I);
    chk("lit_cfg_done", cfg_done, 1);
    for (n = 0; n < LIM; n++) begin
      if (wr_log.size() >= 5) break;
      @(negedge CLK_I);
    end
    chk("rr_log_len_ge5", wr_log.size() >= 5, 1);
    @(posedge CLK_I); #1 req_valid = 4'h0;
    if (wr_log.size() >= 5) begin
      chk("lit_rr0", wr_log[0], 8'hA0);
      chk("lit_rr1", wr_log[1], 8'hA1);
      chk("lit_rr2", wr_log[2], 8'hA2);
      chk("lit_rr3", wr_log[3], 8'hA3);
      chk("lit_rr4", wr_log[4], 8'hA0);
    end
    wait_idle("rr_idle");

    // Single requester 2.
    @(posedge CLK_I); #1
    wr_log.delete();
    req_data[23:16] = 8'h55;
    req_valid = 4'b0100;
    wait_grant("r2_grant");
    chk("lit_r2_ready", req_ready, 4'b0100);
    @(posedge CLK_I); #1 req_valid = 4'h0;
    cnt = 0;
    for (n = 0; n < LIM; n++) begin
      @(negedge CLK_I);
      cnt++;
      if (!busy) break;
    end
    chk("lit_r2_busy_latency", cnt, 6);
    chk("lit_r2_log_len", wr_log.size(), 1);
    if (wr_log.size() >= 1) chk("lit_r2_byte", wr_log[0], 8'h55);

    // Transmitter busy for 500 cycles.
    @(posedge CLK_I); #1
    lsr_ts = 1'b0;
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    wait_grant("poll_grant");
    @(posedge CLK_I); #1 req_valid = 4'h0;
    cnt = 0;
    repeat (500) begin
      @(negedge CLK_I);
      if (STB_O && !WE_O && ADD_O == OFF_UART_LSR) cnt++;
    end
    chk("lit_poll_cycles", cnt, 500);
    @(posedge CLK_I); #1 lsr_ts = 1'b1;
    @(negedge CLK_I);
    chk("lit_poll_still_read", WE_O, 0);
    @(negedge CLK_I);
    chk("lit_send_we", WE_O, 1);
    chk("lit_send_dat", DAT_O, 32'h3C);
    wait_idle("poll_idle");

    // Reset while settling after a write.
    @(posedge CLK_I); #1
    req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    wait_write("rw_write");
    @(posedge CLK_I); #1 RST_N_I = 1'b0;
    @(negedge CLK_I);
    chk("lit_rw_stb", STB_O, 0);
    chk("lit_rw_dat", DAT_O, 0);
    chk("lit_rw_cfg", cfg_done, 0);
    @(posedge CLK_I); #1 req_valid = 4'h0;
    @(posedge CLK_I); #1 RST_N_I = 1'b1;
    @(negedge CLK_I);
    chk("lit_rw_redo_divr", ADD_O, OFF_UART_DIVR);
    wait_idle("rw_idle");

    // Reset while polling: the buffered byte must never reach DATA.
    @(posedge CLK_I); #1
    lsr_ts = 1'b0;
    req_data[23:16] = 8'h99;
    req_valid = 4'b0100;
    wait_grant("rp_grant");
    @(posedge CLK_I); #1 req_valid = 4'h0;
    @(posedge CLK_I); #1 RST_N_I = 1'b0;
    @(negedge CLK_I);
    chk("lit_rp_stb", STB_O, 0);
    chk("lit_rp_add", ADD_O, 0);
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1
    RST_N_I = 1'b1;
    lsr_ts = 1'b1;
    wr_log.delete();
    repeat (30) @(negedge CLK_I);
    chk("lit_rp_no_data_write", wr_log.size(), 0);

    // Requester 1 pulses during settle; requester 3 holds and wins.
    @(posedge CLK_I); #1
    req_data = {8'hD3, 8'h00, 8'hEE, 8'h11};
    req_valid = 4'b0001;
    wait_grant("pw_grant0");
    @(posedge CLK_I); #1 req_valid = 4'h0;
    wait_write("pw_write0");
    @(posedge CLK_I); #1 req_valid = 4'b1010;
    @(posedge CLK_I); #1 req_valid = 4'b1000;
    wait_grant("pw_grant3");
    chk("lit_pw_ready", req_ready, 4'b1000);
    @(posedge CLK_I); #1 req_valid = 4'h0;
    wait_write("pw_write3");
    chk("lit_pw_dat", DAT_O, 32'hD3);
    wait_idle("pw_idle");
    chk("lit_pw_log_len", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      chk("lit_pw_log0", wr_log[0], 8'h11);
      chk("lit_pw_log1", wr_log[1], 8'hD3);
    end

    repeat (3) @(negedge CLK_I);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
